// File: rtl/mc_controller_hs.sv
// Multicycle RV32I control FSM with memory wait states, optional M-extension handshake,
// illegal-opcode / memory-timeout trap and a per-instruction retire pulse.
module mc_controller_hs #(
    parameter bit          MULDIV_EN = 1'b0,
    parameter int unsigned MEM_TMO   = 32'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       funct7b0,
    input  logic [3:0] Flags,
    input  logic       mem_ready,
    input  logic       muldiv_done,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic [2:0] LoadType,
    output logic [1:0] StoreType,
    output logic       muldiv_start,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic       retire
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXR    = 4'd6,  S_EXI    = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11,
        S_LUI    = 4'd12, S_AUIPC  = 4'd13, S_MULDIV = 4'd14, S_TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_MEMTMO  = 2'b10;

    localparam int WDT_W = (MEM_TMO > 32'd1) ? $clog2(MEM_TMO) + 1 : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(MEM_TMO - 32'd1);

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic use_sub,
                                           input logic arith);
        logic [3:0] sel;
        case (f3)
            3'b000:  sel = use_sub ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = arith ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            3'b111:  sel = ALU_AND;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

    // Flags are {N,Z,C,V}; C=1 means no borrow, so unsigned-less-than is !C.
    function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] fl);
        logic taken;
        case (f3)
            3'b000:  taken = fl[2];
            3'b001:  taken = !fl[2];
            3'b100:  taken = fl[3] ^ fl[0];
            3'b101:  taken = !(fl[3] ^ fl[0]);
            3'b110:  taken = !fl[1];
            3'b111:  taken = fl[1];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    state_t           state_r, state_next_s;
    logic [WDT_W-1:0] wdt_r;
    logic             md_busy_r;
    logic             trap_r;
    logic [1:0]       cause_r;
    logic [1:0]       cause_set_s;
    logic             waiting_s, wdt_exp_s;
    logic             mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s, md_start_s;

    assign wdt_exp_s = (MEM_TMO != 32'd0) && !mem_ready && (wdt_r == WDT_LAST);

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s = state_r;
        cause_set_s  = 2'b00;
        waiting_s    = 1'b0;
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        md_start_s   = 1'b0;
        AdrSrc       = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        ImmSrc       = 3'b000;
        ALUControl   = ALU_ADD;
        LoadType     = 3'b000;
        StoreType    = 2'b00;
        case (state_r)
            S_FETCH: begin
                mem_req_s = 1'b1;
                waiting_s = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    state_next_s = S_DECODE;
                end else if (wdt_exp_s) begin
                    state_next_s = S_TRAP;
                    cause_set_s  = CAUSE_MEMTMO;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b010;
                case (op)
                    OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
                    OP_REG: begin
                        if (!funct7b0) begin
                            state_next_s = S_EXR;
                        end else if (MULDIV_EN) begin
                            state_next_s = S_MULDIV;
                        end else begin
                            state_next_s = S_TRAP;
                            cause_set_s  = CAUSE_ILLEGAL;
                        end
                    end
                    OP_IMM:    state_next_s = S_EXI;
                    OP_BRANCH: state_next_s = S_BRANCH;
                    OP_JAL:    state_next_s = S_JAL;
                    OP_JALR:   state_next_s = S_JALR;
                    OP_LUI:    state_next_s = S_LUI;
                    OP_AUIPC:  state_next_s = S_AUIPC;
                    default: begin
                        state_next_s = S_TRAP;
                        cause_set_s  = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = 2'b10;
                ALUSrcB      = 2'b01;
                ImmSrc       = op[5] ? 3'b001 : 3'b000;
                state_next_s = op[5] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req_s    = 1'b1;
                waiting_s    = 1'b1;
                AdrSrc       = 1'b1;
                LoadType     = funct3;
                state_next_s = S_MEMRD;
                if (mem_ready) begin
                    state_next_s = S_MEMWB;
                end else if (wdt_exp_s) begin
                    state_next_s = S_TRAP;
                    cause_set_s  = CAUSE_MEMTMO;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                LoadType     = funct3;
                reg_write_s  = 1'b1;
                state_next_s = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                waiting_s   = 1'b1;
                AdrSrc      = 1'b1;
                StoreType   = funct3[1:0];
                if (mem_ready) begin
                    state_next_s = S_FETCH;
                end else if (wdt_exp_s) begin
                    state_next_s = S_TRAP;
                    cause_set_s  = CAUSE_MEMTMO;
                end else begin
                    state_next_s = S_MEMWR;
                end
            end
            S_EXR: begin
                ALUSrcA      = 2'b10;
                ALUControl   = alu_sel(funct3, funct7b5, funct7b5);
                state_next_s = S_ALUWB;
            end
            S_EXI: begin
                ALUSrcA      = 2'b10;
                ALUSrcB      = 2'b01;
                ALUControl   = alu_sel(funct3, 1'b0, funct7b5);
                state_next_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                state_next_s = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                if (funct3[2:1] == 2'b01) begin
                    state_next_s = S_TRAP;
                    cause_set_s  = CAUSE_ILLEGAL;
                end else begin
                    pc_write_s   = branch_taken(funct3, Flags);
                    state_next_s = S_FETCH;
                end
            end
            S_JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_s   = 1'b1;
                state_next_s = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA      = 2'b10;
                ALUSrcB      = 2'b01;
                state_next_s = S_JAL;
            end
            S_LUI: begin
                ImmSrc       = 3'b100;
                ResultSrc    = 2'b11;
                reg_write_s  = 1'b1;
                state_next_s = S_FETCH;
            end
            S_AUIPC: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b01;
                ImmSrc       = 3'b100;
                state_next_s = S_ALUWB;
            end
            S_MULDIV: begin
                md_start_s = !md_busy_r;
                if (muldiv_done) begin
                    reg_write_s  = 1'b1;
                    ResultSrc    = 2'b10;
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MULDIV;
                end
            end
            S_TRAP:  state_next_s = S_TRAP;
            default: state_next_s = S_TRAP;
        endcase
    end

    // Reset cycle must not commit any architectural write, whatever state it interrupts.
    assign mem_req      = mem_req_s & ~reset;
    assign MemWrite     = mem_write_s & ~reset;
    assign IRWrite      = ir_write_s & ~reset;
    assign PCWrite      = pc_write_s & ~reset;
    assign RegWrite     = reg_write_s & ~reset;
    assign muldiv_start = md_start_s & ~reset;
    assign retire       = (state_next_s == S_FETCH) && (state_r != S_FETCH) && !reset;
    assign trap         = trap_r;
    assign trap_cause   = cause_r;

    // State, watchdog, M-unit first-cycle tracking and sticky trap registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= S_FETCH;
            wdt_r     <= '0;
            md_busy_r <= 1'b0;
            trap_r    <= 1'b0;
            cause_r   <= 2'b00;
        end else begin
            state_r   <= state_next_s;
            md_busy_r <= (state_r == S_MULDIV) && (state_next_s == S_MULDIV);
            if (waiting_s && !mem_ready && (state_next_s == state_r)) begin
                wdt_r <= wdt_r + WDT_W'(1);
            end else begin
                wdt_r <= '0;
            end
            if ((state_next_s == S_TRAP) && (state_r != S_TRAP)) begin
                trap_r  <= 1'b1;
                cause_r <= cause_set_s;
            end else begin
                trap_r  <= trap_r;
                cause_r <= cause_r;
            end
        end
    end

endmodule

// File: tb/tb_mc_controller_hs.sv
// Directed bench for mc_controller_hs (MULDIV_EN=1, MEM_TMO=8); expected values are hand-derived.
module tb_mc_controller_hs;
    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, funct7b0;
    logic [3:0] Flags;
    logic       mem_ready, muldiv_done;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [2:0] LoadType;
    logic [1:0] StoreType;
    logic       muldiv_start, trap, retire;
    logic [1:0] trap_cause;
    int         tests, fails;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPR = 7'b0110011,
                           OPI = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    mc_controller_hs #(.MULDIV_EN(1'b1), .MEM_TMO(32'd8)) dut (
        .clock(clock), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .funct7b0(funct7b0), .Flags(Flags), .mem_ready(mem_ready), .muldiv_done(muldiv_done),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .LoadType(LoadType),
        .StoreType(StoreType), .muldiv_start(muldiv_start), .trap(trap),
        .trap_cause(trap_cause), .retire(retire)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt(input logic rdy, input logic done);
        @(negedge clock);
        mem_ready   = rdy;
        muldiv_done = done;
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic b5,
                             input logic b0);
        op = o; funct3 = f3; funct7b5 = b5; funct7b0 = b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; mem_ready = 1'b0; muldiv_done = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    logic [7:0]  br_tab [0:6];
    logic [14:0] ex_tab [0:6];
    logic [7:0]  be;
    logic [14:0] ee;

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; Flags = 4'b0000; mem_ready = 1'b0; muldiv_done = 1'b0;
        set_instr(OPI, 3'b000, 1'b0, 1'b0);
        // {funct3, Flags{N,Z,C,V}, taken}
        br_tab = '{ {3'b000, 4'b0100, 1'b1}, {3'b000, 4'b0000, 1'b0}, {3'b001, 4'b0000, 1'b1},
                    {3'b100, 4'b1000, 1'b1}, {3'b101, 4'b1001, 1'b1}, {3'b110, 4'b0010, 1'b0},
                    {3'b111, 4'b0010, 1'b1} };
        // {op, funct3, funct7b5, ALUControl}
        ex_tab = '{ {OPR, 3'b000, 1'b1, 4'd1}, {OPR, 3'b101, 1'b1, 4'd9}, {OPR, 3'b010, 1'b0, 4'd5},
                    {OPI, 3'b000, 1'b1, 4'd0}, {OPI, 3'b101, 1'b0, 4'd8}, {OPI, 3'b111, 1'b0, 4'd2},
                    {OPI, 3'b011, 1'b0, 4'd6} };

        do_reset();
        chk("rst_memreq", mem_req, 1'b1);
        chk("rst_trap", trap, 1'b0);
        chk("rst_cause", trap_cause, 2'b00);
        chk("rst_wait_irwrite", IRWrite, 1'b0);
        chk("rst_wait_pcwrite", PCWrite, 1'b0);

        // addi x1,x0,5
        nxt(1'b1, 1'b0);
        chk("addi_fetch_ir", IRWrite, 1'b1);
        chk("addi_fetch_pc", PCWrite, 1'b1);
        chk("addi_fetch_srcb", ALUSrcB, 2'b10);
        chk("addi_fetch_res", ResultSrc, 2'b10);
        nxt(1'b1, 1'b0);
        chk("addi_dec_srca", ALUSrcA, 2'b01);
        chk("addi_dec_imm", ImmSrc, 3'b010);
        chk("addi_dec_ir", IRWrite, 1'b0);
        nxt(1'b1, 1'b0);
        chk("addi_exi_srca", ALUSrcA, 2'b10);
        chk("addi_exi_srcb", ALUSrcB, 2'b01);
        chk("addi_exi_rw", RegWrite, 1'b0);
        nxt(1'b1, 1'b0);
        chk("addi_wb_rw", RegWrite, 1'b1);
        chk("addi_wb_retire", retire, 1'b1);

        // lw with three wait cycles in MEMRD
        set_instr(LOAD, 3'b010, 1'b0, 1'b0);
        nxt(1'b1, 1'b0);
        chk("lw_fetch_retire", retire, 1'b0);
        chk("lw_fetch_rw", RegWrite, 1'b0);
        nxt(1'b1, 1'b0);
        nxt(1'b1, 1'b0);
        chk("lw_adr_srca", ALUSrcA, 2'b10);
        chk("lw_adr_imm", ImmSrc, 3'b000);
        chk("lw_adr_memreq", mem_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            nxt(1'b0, 1'b0);
            chk("lw_wait_memreq", mem_req, 1'b1);
            chk("lw_wait_adrsrc", AdrSrc, 1'b1);
            chk("lw_wait_rw", RegWrite, 1'b0);
        end
        nxt(1'b1, 1'b0);
        chk("lw_rd_memreq", mem_req, 1'b1);
        chk("lw_rd_loadtype", LoadType, 3'b010);
        nxt(1'b1, 1'b0);
        chk("lw_wb_rw", RegWrite, 1'b1);
        chk("lw_wb_res", ResultSrc, 2'b01);
        chk("lw_wb_retire", retire, 1'b1);

        // sw, memory ready immediately
        set_instr(STORE, 3'b010, 1'b0, 1'b0);
        nxt(1'b1, 1'b0); nxt(1'b1, 1'b0); nxt(1'b1, 1'b0);
        chk("sw_adr_imm", ImmSrc, 3'b001);
        nxt(1'b1, 1'b0);
        chk("sw_wr_memwrite", MemWrite, 1'b1);
        chk("sw_wr_adrsrc", AdrSrc, 1'b1);
        chk("sw_wr_storetype", StoreType, 2'b10);
        chk("sw_wr_retire", retire, 1'b1);

        // branch conditions: FETCH, DECODE, BRANCH
        for (int i = 0; i < 7; i++) begin
            be = br_tab[i];
            set_instr(BR, be[7:5], 1'b0, 1'b0);
            Flags = be[4:1];
            nxt(1'b1, 1'b0);
            chk("br_fetch_memreq", mem_req, 1'b1);
            nxt(1'b1, 1'b0);
            nxt(1'b1, 1'b0);
            chk("br_pcwrite", PCWrite, be[0]);
            chk("br_alu_sub", ALUControl, 4'd1);
            chk("br_retire", retire, 1'b1);
        end

        // register / immediate ALU ops
        for (int i = 0; i < 7; i++) begin
            ee = ex_tab[i];
            set_instr(ee[14:8], ee[7:5], ee[4], 1'b0);
            nxt(1'b1, 1'b0); nxt(1'b1, 1'b0); nxt(1'b1, 1'b0);
            chk("ex_aluctl", ALUControl, ee[3:0]);
            chk("ex_srcb", ALUSrcB, (ee[14:8] == OPI) ? 2'b01 : 2'b00);
            nxt(1'b1, 1'b0);
            chk("ex_wb_rw", RegWrite, 1'b1);
            chk("ex_wb_retire", retire, 1'b1);
        end

        // jalr -> jal -> aluwb
        set_instr(JALR, 3'b000, 1'b0, 1'b0);
        nxt(1'b1, 1'b0); nxt(1'b1, 1'b0); nxt(1'b1, 1'b0);
        chk("jalr_srca", ALUSrcA, 2'b10);
        chk("jalr_pcwrite", PCWrite, 1'b0);
        nxt(1'b1, 1'b0);
        chk("jal_pcwrite", PCWrite, 1'b1);
        chk("jal_srcb", ALUSrcB, 2'b10);
        chk("jal_srca", ALUSrcA, 2'b01);
        nxt(1'b1, 1'b0);
        chk("jal_wb_retire", retire, 1'b1);

        // lui, auipc
        set_instr(LUI, 3'b000, 1'b0, 1'b0);
        nxt(1'b1, 1'b0); nxt(1'b1, 1'b0); nxt(1'b1, 1'b0);
        chk("lui_res", ResultSrc, 2'b11);
        chk("lui_imm", ImmSrc, 3'b100);
        chk("lui_rw", RegWrite, 1'b1);
        chk("lui_retire", retire, 1'b1);
        set_instr(AUIPC, 3'b000, 1'b0, 1'b0);
        nxt(1'b1, 1'b0); nxt(1'b1, 1'b0); nxt(1'b1, 1'b0);
        chk("auipc_imm", ImmSrc, 3'b100);
        chk("auipc_retire", retire, 1'b0);
        nxt(1'b1, 1'b0);
        chk("auipc_wb_retire", retire, 1'b1);

        // mul, done on fifth MULDIV cycle
        set_instr(OPR, 3'b000, 1'b0, 1'b1);
        nxt(1'b1, 1'b0); nxt(1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            nxt(1'b1, k == 5);
            chk("mul_start", muldiv_start, k == 1);
            chk("mul_rw", RegWrite, k == 5);
            chk("mul_retire", retire, k == 5);
        end
        chk("mul_res", ResultSrc, 2'b10);

        // reset in the middle of MULDIV while done is high
        nxt(1'b1, 1'b0); nxt(1'b1, 1'b0); nxt(1'b1, 1'b0);
        @(negedge clock);
        reset = 1'b1; muldiv_done = 1'b1;
        #1;
        chk("mdrst_rw", RegWrite, 1'b0);
        chk("mdrst_retire", retire, 1'b0);
        @(negedge clock);
        reset = 1'b0; muldiv_done = 1'b0; mem_ready = 1'b0;
        #1;
        chk("mdrst_fetch_memreq", mem_req, 1'b1);
        chk("mdrst_fetch_start", muldiv_start, 1'b0);

        // illegal opcode
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        nxt(1'b1, 1'b0); nxt(1'b1, 1'b0);
        chk("ill_dec_trap", trap, 1'b0);
        for (int i = 0; i < 4; i++) begin
            nxt(1'b1, 1'b0);
            chk("ill_trap", trap, 1'b1);
            chk("ill_cause", trap_cause, 2'b01);
            chk("ill_memreq", mem_req, 1'b0);
            chk("ill_strobes", {IRWrite, PCWrite, RegWrite, MemWrite}, 4'b0000);
        end
        do_reset();
        chk("ill_rec_trap", trap, 1'b0);
        chk("ill_rec_memreq", mem_req, 1'b1);

        // reserved branch funct3 traps without retiring
        set_instr(BR, 3'b010, 1'b0, 1'b0);
        nxt(1'b1, 1'b0); nxt(1'b1, 1'b0); nxt(1'b1, 1'b0);
        chk("brill_pcwrite", PCWrite, 1'b0);
        chk("brill_retire", retire, 1'b0);
        nxt(1'b1, 1'b0);
        chk("brill_cause", trap_cause, 2'b01);

        // watchdog: ready arriving on the 8th wait cycle wins
        do_reset();
        set_instr(LUI, 3'b000, 1'b0, 1'b0);
        for (int k = 2; k <= 7; k++) begin
            nxt(1'b0, 1'b0);
            chk("wd_pre_trap", trap, 1'b0);
        end
        nxt(1'b1, 1'b0);
        chk("wd_ready_wins", IRWrite, 1'b1);
        nxt(1'b1, 1'b0);
        chk("wd_ready_notrap", trap, 1'b0);
        nxt(1'b1, 1'b0);
        chk("wd_lui_retire", retire, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            nxt(1'b0, 1'b0);
            chk("wd_wait_memreq", mem_req, 1'b1);
            chk("wd_wait_trap", trap, 1'b0);
        end
        nxt(1'b0, 1'b0);
        chk("wd_trap", trap, 1'b1);
        chk("wd_cause", trap_cause, 2'b10);
        chk("wd_memreq", mem_req, 1'b0);
        do_reset();
        chk("wd_rec_trap", trap, 1'b0);
        chk("wd_rec_cause", trap_cause, 2'b00);
        chk("wd_rec_memreq", mem_req, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
